vc_rr_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/vc_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_vc_rr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// noc_pkg : shared flit format, VC sizing and arbiter state encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
package noc_pkg;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int FLIT_W = 34;

    localparam logic [1:0] HEAD_FLIT = 2'b00;
    localparam logic [1:0] BODY_FLIT = 2'b01;
    localparam logic [1:0] TAIL_FLIT = 2'b11;
    localparam logic [1:0] RSVD_FLIT = 2'b10;

    localparam int TYPE_HI = 33;
    localparam int TYPE_LO = 32;
    localparam int SIZE_HI = 29;
    localparam int SIZE_LO = 22;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin priority pick starting at i_ptr.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_VC = 4,
    parameter int VC_W   = 2
) (
    input  logic [NUM_VC-1:0] i_req,
    input  logic [VC_W-1:0]   i_ptr,
    output logic [NUM_VC-1:0] o_grant,
    output logic [VC_W-1:0]   o_grant_id
);
    logic            w_found;
    logic [VC_W-1:0] w_idx;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_idx = VC_W'((int'(i_ptr) + i) % NUM_VC);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
                w_found        = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vc_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_rr_arbiter : per-packet round-robin VC selection with wormhole lock and
//                 a single registered output stage.   Revision: 1.0
// ---------------------------------------------------------------------------
module vc_rr_arbiter #(
    parameter int NUM_VC = 4,
    parameter int VC_W   = 2,
    parameter int FLIT_W = 34
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [NUM_VC*FLIT_W-1:0] fdata_i,
    input  logic [NUM_VC-1:0]        valid_i,
    output logic [NUM_VC-1:0]        ready_o,
    output logic [FLIT_W-1:0]        fdata_o,
    output logic [VC_W-1:0]          vc_id_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     locked_o
);
    import noc_pkg::*;

    arb_state_e        r_state;
    logic [VC_W-1:0]   r_rr_ptr;
    logic [VC_W-1:0]   r_lock_vc;
    logic [VC_W-1:0]   r_vc_id;
    logic [FLIT_W-1:0] r_fdata;
    logic              r_valid;
    logic              r_locked;

    logic [NUM_VC-1:0] w_grant_oh;
    logic [VC_W-1:0]   w_grant_id;
    logic [VC_W-1:0]   w_sel_vc;
    logic [VC_W-1:0]   w_ptr_next;
    logic [FLIT_W-1:0] w_vc_flit [NUM_VC];
    logic [FLIT_W-1:0] w_flit;
    logic [1:0]        w_type;
    logic [7:0]        w_size;
    logic              w_out_free;
    logic              w_xfer;
    logic              w_head_long;
    logic              w_tail_like;
    logic              w_ends;

    generate
        for (genvar v = 0; v < NUM_VC; v++) begin : g_slice
            assign w_vc_flit[v] = fdata_i[v*FLIT_W +: FLIT_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_VC (NUM_VC),
        .VC_W   (VC_W)
    ) u_rr (
        .i_req      (valid_i),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant_oh),
        .o_grant_id (w_grant_id)
    );

    assign w_out_free = !r_valid || ready_i;
    assign w_sel_vc   = (r_state == LOCKED) ? r_lock_vc : w_grant_id;

    // The locked VC is offered a pop regardless of its valid; a transfer still needs both.
    always_comb begin
        ready_o = '0;
        if (!arst && w_out_free) begin
            if (r_state == LOCKED) begin
                ready_o[r_lock_vc] = 1'b1;
            end else begin
                ready_o = w_grant_oh;
            end
        end
    end

    assign w_xfer      = |(valid_i & ready_o);
    assign w_flit      = w_vc_flit[w_sel_vc];
    assign w_type      = w_flit[TYPE_HI:TYPE_LO];
    assign w_size      = w_flit[SIZE_HI:SIZE_LO];
    assign w_head_long = (w_type == HEAD_FLIT) && (w_size != 8'd0);
    assign w_tail_like = (w_type == TAIL_FLIT) || (w_type == RSVD_FLIT);
    // A size-0 head only closes a packet when no lock is held.
    assign w_ends      = w_tail_like ||
                         ((r_state == IDLE) && (w_type == HEAD_FLIT) && (w_size == 8'd0));
    assign w_ptr_next  = VC_W'((int'(w_sel_vc) + 1) % NUM_VC);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_lock_vc <= '0;
            r_locked  <= 1'b0;
            r_valid   <= 1'b0;
            r_fdata   <= '0;
            r_vc_id   <= '0;
        end else begin
            if (w_xfer) begin
                case (r_state)
                    IDLE: begin
                        if (w_head_long) begin
                            r_state   <= LOCKED;
                            r_lock_vc <= w_grant_id;
                            r_locked  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_tail_like) begin
                            r_state  <= IDLE;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
                if (w_ends) begin
                    r_rr_ptr <= w_ptr_next;
                end
            end
            if (w_out_free) begin
                r_valid <= w_xfer;
                if (w_xfer) begin
                    r_fdata <= w_flit;
                    r_vc_id <= w_sel_vc;
                end
            end
        end
    end

    assign fdata_o  = r_fdata;
    assign vc_id_o  = r_vc_id;
    assign valid_o  = r_valid;
    assign locked_o = r_locked;
endmodule
`default_nettype wire

// File: tb/tb_vc_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vc_rr_arbiter : directed + random traffic against a packet-level model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vc_rr_arbiter;
    localparam int NV = 4;
    localparam int VW = 2;
    localparam int FW = 34;

    logic             clk = 1'b0;
    logic             arst;
    logic [NV*FW-1:0] fdata_i;
    logic [NV-1:0]    valid_i;
    logic [NV-1:0]    ready_o;
    logic [FW-1:0]    fdata_o;
    logic [VW-1:0]    vc_id_o;
    logic             valid_o;
    logic             ready_i;
    logic             locked_o;

    logic [FW-1:0]    tb_flit [NV];
    assign fdata_i = {tb_flit[3], tb_flit[2], tb_flit[1], tb_flit[0]};

    always #5 clk = ~clk;

    vc_rr_arbiter #(.NUM_VC(NV), .VC_W(VW), .FLIT_W(FW)) dut (
        .clk      (clk),
        .arst     (arst),
        .fdata_i  (fdata_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .fdata_o  (fdata_o),
        .vc_id_o  (vc_id_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .locked_o (locked_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Flits waiting in each upstream vc_buffer, front = presented flit.
    logic [FW-1:0] q [NV][$];

    // Reference model: lock owner (-1 = none), round-robin start, output register.
    int            m_lock = -1;
    int            m_ptr  = 0;
    bit            m_valid = 1'b0;
    logic [FW-1:0] m_data = '0;
    int            m_vc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int size);
        logic [FW-1:0] f;
        f = FW'({$urandom(), $urandom()});
        f[33:32] = t;
        if (t == 2'b00) f[29:22] = 8'(size);
        return f;
    endfunction

    task automatic push_pkt(input int v, input int size, input bit fixed_tail);
        logic [1:0] tt;
        q[v].push_back(mk(2'b00, size));
        for (int k = 1; k <= size; k++) begin
            tt = (fixed_tail || $urandom_range(3) != 0) ? 2'b11 : 2'b10;
            q[v].push_back(mk((k == size) ? tt : 2'b01, 0));
        end
    endtask

    task automatic step(input bit rst_now, input bit rdy, input int bubble);
        logic [NV-1:0] exp_rdy;
        logic [FW-1:0] f;
        bit            free;
        bit            xfer;
        int            sel;
        int            c;
        @(negedge clk);
        arst    = rst_now;
        ready_i = rdy;
        for (int v = 0; v < NV; v++) begin
            valid_i[v] = (q[v].size() > 0) && ($urandom_range(99) >= bubble);
            tb_flit[v] = (q[v].size() > 0) ? q[v][0] : '0;
        end
        free = !m_valid || rdy;
        sel  = -1;
        if (m_lock >= 0) begin
            sel = m_lock;
        end else begin
            for (int k = 0; k < NV; k++) begin
                c = (m_ptr + k) % NV;
                if (sel < 0 && valid_i[c]) sel = c;
            end
        end
        exp_rdy = '0;
        if (!rst_now && free && sel >= 0) exp_rdy[sel] = 1'b1;
        #1;
        chk("ready_o", 64'(ready_o), 64'(exp_rdy));
        @(posedge clk);
        if (rst_now) begin
            m_lock = -1; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_vc = 0;
        end else begin
            xfer = (exp_rdy != '0) && valid_i[sel];
            if (xfer) begin
                f = q[sel].pop_front();
                m_data = f; m_vc = sel; m_valid = 1'b1;
                if (m_lock < 0) begin
                    if (f[33:32] == 2'b00 && f[29:22] != 8'd0) m_lock = sel;
                    else if (f[33:32] != 2'b01) m_ptr = (sel + 1) % NV;
                end else if (f[33]) begin
                    m_lock = -1;
                    m_ptr  = (sel + 1) % NV;
                end
            end else if (free) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("valid_o",  64'(valid_o),  64'(m_valid));
        chk("fdata_o",  64'(fdata_o),  64'(m_data));
        chk("vc_id_o",  64'(vc_id_o),  64'(m_vc));
        chk("locked_o", 64'(locked_o), 64'(m_lock >= 0));
    endtask

    initial begin
        arst    = 1'b1;
        ready_i = 1'b0;
        valid_i = '0;
        for (int v = 0; v < NV; v++) tb_flit[v] = '0;
        step(1, 0, 0);
        step(1, 0, 0);
        chk("rr_ptr_reset", 64'(dut.r_rr_ptr), 64'd0);

        // Single-flit packet on VC0
        q[0].push_back({2'b00, 2'b00, 8'd0, 22'h0000AA});
        repeat (3) step(0, 1, 0);
        chk("rr_ptr_single", 64'(dut.r_rr_ptr), 64'd1);

        // Wormhole lock on VC1 while VC2 keeps offering
        push_pkt(1, 2, 1);
        repeat (4) push_pkt(2, 0, 1);
        repeat (10) step(0, 1, 0);

        // Round-robin with every VC offering single-flit packets
        for (int v = 0; v < NV; v++) repeat (4) push_pkt(v, 0, 1);
        repeat (20) step(0, 1, 0);

        // Backpressure mid-packet on VC3
        push_pkt(3, 4, 1);
        repeat (2) step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        repeat (8) step(0, 1, 0);

        // Reset after the head of a size-3 packet on VC2
        push_pkt(2, 3, 1);
        for (int k = 0; k < 10 && m_lock != 2; k++) step(0, 1, 0);
        chk("lock_vc2", 64'(m_lock == 2), 64'(locked_o));
        push_pkt(0, 0, 1);
        step(1, 0, 0);
        chk("rr_ptr_midreset", 64'(dut.r_rr_ptr), 64'd0);
        repeat (10) step(0, 1, 0);

        // Stray BODY flit in IDLE
        q[1].push_back(mk(2'b01, 0));
        repeat (3) step(0, 1, 0);

        // Random traffic, backpressure, bubbles and occasional reset
        repeat (800) begin
            if ($urandom_range(2) == 0) begin
                if ($urandom_range(15) == 0) q[$urandom_range(NV-1)].push_back(mk(2'b01, 0));
                else push_pkt($urandom_range(NV-1), $urandom_range(4), 0);
            end
            step($urandom_range(199) == 0, $urandom_range(3) != 0, 20);
        end
        repeat (80) step(0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
